xbar2x2_sched: RTL



---
 rtl/xbar2x2_sched_pkg.sv | 18 +
 rtl/xbar_port_owner.sv | 46 ++++
 rtl/xbar2x2_sched.sv | 124 ++++++++++++
 3 files changed

// File: rtl/xbar2x2_sched_pkg.sv
// Shared constants for the 2x2 crossbar scheduler and its per-input owner.
package xbar2x2_sched_pkg;

    localparam logic CTRL_BAR   = 1'b0;
    localparam logic CTRL_CROSS = 1'b1;

    localparam int OUT0 = 0;
    localparam int OUT1 = 1;

    localparam int DEFAULT_LEN_W = 4;

    // Crossbar select for a route from input src to output dest.
    // A straight route (in0->out0, in1->out1) is BAR, and a swapped one is CROSS.
    function automatic logic route_ctrl(input logic dest, input logic src);
        return (dest ^ src) ? CTRL_CROSS : CTRL_BAR;
    endfunction

endpackage

// File: rtl/xbar_port_owner.sv
// Per-input packet tracker. It holds the busy flag, the owned output port and
// a beat counter that starts at len and stops at zero on the last beat.
module xbar_port_owner
    import xbar2x2_sched_pkg::*;
#(
    parameter int LEN_W = DEFAULT_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             load_dest,
    input  logic [LEN_W-1:0] load_len,
    output logic             busy,
    output logic             dest,
    output logic             last
);

    logic [LEN_W-1:0] cnt_reg;
    logic             busy_reg;
    logic             dest_reg;

    // Load on grant, then count beats down. Busy clears at the edge that ends
    // the zero-count beat, and the counter is never decremented below zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg <= 1'b0;
            dest_reg <= 1'b0;
            cnt_reg  <= '0;
        end else if (load) begin
            busy_reg <= 1'b1;
            dest_reg <= load_dest;
            cnt_reg  <= load_len;
        end else if (busy_reg) begin
            if (cnt_reg == '0) begin
                busy_reg <= 1'b0;
            end else begin
                cnt_reg <= cnt_reg - 1'b1;
            end
        end
    end

    assign busy = busy_reg;
    assign dest = dest_reg;
    assign last = busy_reg && (cnt_reg == '0);

endmodule

// File: rtl/xbar2x2_sched.sv
// Scheduler for a 2x2 crossbar. It arbitrates the two requesters onto the two
// output ports, locks each route for the length of its packet, and drives the
// crossbar select.
module xbar2x2_sched
    import xbar2x2_sched_pkg::*;
#(
    parameter int LEN_W = DEFAULT_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic             req0_dest,
    input  logic [LEN_W-1:0] req0_len,
    input  logic             req1_valid,
    input  logic             req1_dest,
    input  logic [LEN_W-1:0] req1_len,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy0,
    output logic             busy1,
    output logic             control,
    output logic [1:0]       out_valid
);

    logic [1:0]       req_valid;
    logic [1:0]       req_dest;
    logic [LEN_W-1:0] req_len [2];

    logic [1:0] busy;
    logic [1:0] owner_dest;
    logic [1:0] last;
    logic [1:0] eligible;
    logic [1:0] grant;
    logic [1:0] port_owned;
    logic [1:0] busy_next;
    logic [1:0] dest_next;
    logic [1:0] out_valid_next;

    logic       conflict;
    logic       rr_next;
    logic       control_next;

    logic [1:0] gnt_reg;
    logic [1:0] out_valid_reg;
    logic       rr_reg;
    logic       control_reg;

    assign req_valid  = {req1_valid, req0_valid};
    assign req_dest   = {req1_dest, req0_dest};
    assign req_len[0] = req0_len;
    assign req_len[1] = req1_len;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_input
            xbar_port_owner #(
                .LEN_W(LEN_W)
            ) u_owner (
                .clk      (clk),
                .rst      (rst),
                .load     (grant[gi]),
                .load_dest(req_dest[gi]),
                .load_len (req_len[gi]),
                .busy     (busy[gi]),
                .dest     (owner_dest[gi]),
                .last     (last[gi])
            );

            // A port freed at this edge still reads as owned here, which is
            // what inserts the single idle cycle between back-to-back packets.
            assign eligible[gi]  = req_valid[gi] & ~busy[gi] & ~port_owned[req_dest[gi]];
            assign busy_next[gi] = grant[gi] | (busy[gi] & ~last[gi]);
            assign dest_next[gi] = grant[gi] ? req_dest[gi] : owner_dest[gi];
        end

        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign port_owned[gi] = (busy[0] & (owner_dest[0] == 1'(gi)))
                                  | (busy[1] & (owner_dest[1] == 1'(gi)));
            assign out_valid_next[gi] = (busy_next[0] & (dest_next[0] == 1'(gi)))
                                      | (busy_next[1] & (dest_next[1] == 1'(gi)));
        end
    endgenerate

    // Arbitration. A same-dest conflict goes to rr, and rr then passes to the
    // loser. Concurrent grants always have distinct dests, so they produce the
    // same select value.
    always_comb begin
        conflict     = eligible[0] & eligible[1] & (req_dest[0] == req_dest[1]);
        grant        = eligible;
        rr_next      = rr_reg;
        control_next = control_reg;
        if (conflict) begin
            grant   = rr_reg ? 2'b10 : 2'b01;
            rr_next = ~rr_reg;
        end
        if (grant[0]) begin
            control_next = route_ctrl(req_dest[0], 1'b0);
        end else if (grant[1]) begin
            control_next = route_ctrl(req_dest[1], 1'b1);
        end
    end

    // Register the grant pulses, the select, the fairness pointer and the port flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_reg       <= 2'b00;
            out_valid_reg <= 2'b00;
            rr_reg        <= 1'b0;
            control_reg   <= CTRL_BAR;
        end else begin
            gnt_reg       <= grant;
            out_valid_reg <= out_valid_next;
            rr_reg        <= rr_next;
            control_reg   <= control_next;
        end
    end

    assign gnt0      = gnt_reg[0];
    assign gnt1      = gnt_reg[1];
    assign busy0     = busy[0];
    assign busy1     = busy[1];
    assign control   = control_reg;
    assign out_valid = out_valid_reg;

endmodule
